key_event_arbiter: RTL and testbench
====================================

Name: key_event_arbiter

Overview:
- Collects debounced press/release events from KEY_NUM parallel key_filter instances.
- Arbitrates them round-robin into one serial event stream with a valid/ready handshake.
- Sits between the key_filter bank and downstream consumers (LED/counter/UART logic).
- Holds one pending event per key and flags per-key overruns when a consumer stalls.

Parameters:
KEY_NUM, 4, number of key channels (2..16)
ID_W, 2, key index width; 2**ID_W >= KEY_NUM

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
i_Key_flag  in  KEY_NUM  per-key 1-cycle event pulse from key_filter o_KEY_flag
i_Key_state  in  KEY_NUM  per-key debounced level from key_filter o_KEY_State; 0 = pressed, 1 = released
o_Evt_valid  out  1  event available on o_Evt_key/o_Evt_press
i_Evt_ready  in  1  consumer accepts event when high with o_Evt_valid
o_Evt_key  out  ID_W  key index of presented event
o_Evt_press  out  1  1 = press event, 0 = release event
o_Ovr  out  KEY_NUM  sticky per-key overrun flags
i_Ovr_clr  in  1  synchronous clear of all o_Ovr bits

Behaviour:
- Reset (async, rst=1): pend[]=0, kind[]=0, rr_ptr=0, state=IDLE, o_Evt_valid=0, o_Evt_key=0, o_Evt_press=0, o_Ovr=0.
- Capture, per key k, each edge with i_Key_flag[k]=1:
  - pend[k] <= 1; kind[k] <= ~i_Key_state[k], sampled in the same cycle as the flag.
  - If pend[k] is already 1 and is not granted on this edge: kind is overwritten with the newer event, the old event is lost, and o_Ovr[k] <= 1.
- Grant:
  - Occurs on an edge where the output slot is free: state IDLE, or state HOLD with i_Evt_ready=1.
  - Among set pend bits, the winner is the first index found searching rr_ptr, rr_ptr+1, ... modulo KEY_NUM.
  - Winner w: o_Evt_key<=w, o_Evt_press<=kind[w], pend[w]<=0, rr_ptr <= (w+1) mod KEY_NUM, state<=HOLD.
- If the slot is free and no pend bit is set: state<=IDLE, o_Evt_valid<=0; o_Evt_key/o_Evt_press keep their last value.
- FSM:
  - IDLE (o_Evt_valid=0): go to HOLD on grant.
  - HOLD (o_Evt_valid=1): o_Evt_key/o_Evt_press stay stable while i_Evt_ready=0.
  - HOLD with i_Evt_ready=1: transfer completes; on the same edge, grant the next pending key (stay HOLD) or go to IDLE. Throughput is 1 event/clk.
- Latency: flag sampled at edge t -> pend set at t -> o_Evt_valid high after edge t+1, provided no stall and no higher-priority pending key.
- Same-edge grant and new flag on key w: the granted event is the old kind[w]. pend[w] stays 1 with the new kind. No overrun.
- Pend bits are only examined after registration; a flag never bypasses to the output on the edge it arrives.
- i_Ovr_clr=1 clears all o_Ovr bits. A new overrun on the same edge wins, and that bit is set.
- rr_ptr moves only on a grant. A key stalled by i_Evt_ready=0 keeps its pend bit; no event is dropped except by overrun.
- Mid-operation reset discards pending and presented events immediately, with no handshake completion.

Test Plan:
- Single event: key 1 press (flag=1, state=0) with ready=1 -> o_Evt_valid high for exactly 1 cycle, 2 clocks after the flag; key=1, press=1; o_Ovr=0.
- Simultaneous flags: keys 0 and 2 (0 press, 2 release), rr_ptr=0, ready=1 -> back-to-back events (key0, press=1) then (key2, press=0); rr_ptr ends at 3.
- Fairness: keys 0 and 3 re-flagged every 4 cycles with ready=1, rr_ptr initially 1 -> key 3 granted first, then 0. Alternation holds; neither key is granted twice in a row while the other is pending.
- Backpressure/overrun: ready=0; key 2 flags press, then release 5 cycles later -> o_Ovr[2]=1.
  - ready=1 -> one event, key=2, press=0.
  - i_Ovr_clr pulse -> o_Ovr=0.
- Same-edge grant + flag: key 1 pending press; a release flag on key 1 coincides with its grant edge -> events (1,press=1) then (1,press=0); o_Ovr[1]=0.
- Reset mid-stream: rst asserted asynchronously while o_Evt_valid=1 with 3 keys pending -> o_Evt_valid=0 before the next clock edge. After rst release, no event appears until a new flag arrives.

Source files
------------

// File: rtl/key_event_arbiter.sv
// Round-robin arbiter that merges per-key press/release pulses into one
// valid/ready event stream, holding one pending event per key.
module key_event_arbiter #(
  parameter int KEY_NUM = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] i_Key_flag,
  input  logic [KEY_NUM-1:0] i_Key_state,
  output logic               o_Evt_valid,
  input  logic               i_Evt_ready,
  output logic [ID_W-1:0]    o_Evt_key,
  output logic               o_Evt_press,
  output logic [KEY_NUM-1:0] o_Ovr,
  input  logic               i_Ovr_clr
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [KEY_NUM-1:0] pend_q;
  logic [KEY_NUM-1:0] pend_d;
  logic [KEY_NUM-1:0] kind_q;
  logic [KEY_NUM-1:0] kind_d;
  logic [KEY_NUM-1:0] ovr_d;
  logic [KEY_NUM-1:0] ovr_set;
  logic [KEY_NUM-1:0] grant_oh;

  logic [ID_W-1:0] rr_q;
  logic [ID_W-1:0] rr_d;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] key_d;

  logic found;
  logic slot_free;
  logic grant;
  logic press_d;

  assign o_Evt_valid = (state_q == HOLD);
  assign slot_free   = (state_q == IDLE) | i_Evt_ready;
  assign grant       = slot_free & found;

  // Rotating search starting at rr_q; first set pend bit wins.
  always_comb begin
    int idx;
    logic [ID_W-1:0] sel;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    sel   = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      idx = (int'(rr_q) + i) % KEY_NUM;
      sel = ID_W'(idx);
      if (!found && pend_q[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (grant) begin
      grant_oh[win] = 1'b1;
    end
  end

  // A flag on a key being granted this edge re-arms it without overrun.
  always_comb begin
    ovr_set = i_Key_flag & pend_q & ~grant_oh;
    pend_d  = (pend_q & ~grant_oh) | i_Key_flag;
    kind_d  = (kind_q & ~i_Key_flag) | (~i_Key_state & i_Key_flag);
    ovr_d   = (i_Ovr_clr ? '0 : o_Ovr) | ovr_set;
  end

  always_comb begin
    int nxt;
    state_d = state_q;
    key_d   = o_Evt_key;
    press_d = o_Evt_press;
    rr_d    = rr_q;
    nxt     = int'(win) + 1;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (found) begin
          state_d = HOLD;
        end
      end
      (state_q == HOLD): begin
        if (i_Evt_ready) begin
          state_d = found ? HOLD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      key_d   = win;
      press_d = kind_q[win];
      rr_d    = (nxt >= KEY_NUM) ? '0 : ID_W'(nxt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      kind_q      <= '0;
      rr_q        <= '0;
      o_Evt_key   <= '0;
      o_Evt_press <= 1'b0;
      o_Ovr       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      kind_q      <= kind_d;
      rr_q        <= rr_d;
      o_Evt_key   <= key_d;
      o_Evt_press <= press_d;
      o_Ovr       <= ovr_d;
    end
  end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: directed scenarios plus random traffic
// against an event-level reference model.
module tb_key_event_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] i_Key_flag = '0;
  logic [N-1:0] i_Key_state = '1;
  logic         o_Evt_valid;
  logic         i_Evt_ready = 1'b1;
  logic [1:0]   o_Evt_key;
  logic         o_Evt_press;
  logic [N-1:0] o_Ovr;
  logic         i_Ovr_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] m_pend;
  logic [N-1:0] m_kind;
  logic [N-1:0] m_ovr;
  int           m_rr;
  logic         m_valid;
  int           m_key;
  logic         m_press;

  key_event_arbiter #(.KEY_NUM(N), .ID_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .i_Key_flag(i_Key_flag),
    .i_Key_state(i_Key_state),
    .o_Evt_valid(o_Evt_valid),
    .i_Evt_ready(i_Evt_ready),
    .o_Evt_key(o_Evt_key),
    .o_Evt_press(o_Evt_press),
    .o_Ovr(o_Ovr),
    .i_Ovr_clr(i_Ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_pend  = '0;
    m_kind  = '0;
    m_ovr   = '0;
    m_rr    = 0;
    m_valid = 1'b0;
    m_key   = 0;
    m_press = 1'b0;
  endtask

  // One clock of the event rules, applied to the inputs seen at the edge.
  task automatic model_step();
    bit           free;
    int           w;
    logic [N-1:0] old_kind;
    logic [N-1:0] ovr_new;
    free     = !m_valid || i_Evt_ready;
    w        = -1;
    old_kind = m_kind;
    ovr_new  = '0;
    if (free) begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_rr + i) % N;
        if (w < 0 && m_pend[j]) w = j;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (i_Key_flag[k]) begin
        if (m_pend[k] && w != k) ovr_new[k] = 1'b1;
        m_pend[k] = 1'b1;
        m_kind[k] = ~i_Key_state[k];
      end else if (w == k) begin
        m_pend[k] = 1'b0;
      end
    end
    if (i_Ovr_clr) m_ovr = '0;
    m_ovr = m_ovr | ovr_new;
    if (free) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_key   = w;
        m_press = old_kind[w];
        m_rr    = (w + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic tick(input logic [N-1:0] f, input logic [N-1:0] s,
                      input logic r, input logic c);
    i_Key_flag  = f;
    i_Key_state = s;
    i_Evt_ready = r;
    i_Ovr_clr   = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_Key_flag  = '0;
    i_Key_state = '1;
    i_Evt_ready = 1'b1;
    i_Ovr_clr   = 1'b0;
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    model_clear();
    @(negedge clk);
    checks++;
    if ({o_Evt_valid, o_Evt_key, o_Evt_press, o_Ovr} !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold got v=%b k=%0d p=%b ovr=%b want all 0",
               o_Evt_valid, o_Evt_key, o_Evt_press, o_Ovr);
    end
    rst = 1'b0;
    tick('0, '1, 1'b1, 1'b0);
    checks++;
    if ({o_Evt_valid, o_Evt_key, o_Evt_press, o_Ovr} !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle got v=%b k=%0d p=%b ovr=%b want all 0",
               o_Evt_valid, o_Evt_key, o_Evt_press, o_Ovr);
    end
  endtask

  task automatic test_single();
    do_reset();
    tick(4'b0010, 4'b1101, 1'b1, 1'b0);
    checks++;
    if (o_Evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_no_bypass valid=%b want 0", o_Evt_valid);
    end
    tick('0, '1, 1'b1, 1'b0);
    checks++;
    if ({o_Evt_valid, o_Evt_key, o_Evt_press} !== 4'b1011) begin
      errors++;
      $display("FAIL single_evt got v=%b k=%0d p=%b want v=1 k=1 p=1",
               o_Evt_valid, o_Evt_key, o_Evt_press);
    end
    tick('0, '1, 1'b1, 1'b0);
    checks++;
    if (o_Evt_valid !== 1'b0 || o_Ovr !== 4'b0000) begin
      errors++;
      $display("FAIL single_one_cycle got v=%b ovr=%b want v=0 ovr=0000",
               o_Evt_valid, o_Ovr);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    tick(4'b0101, 4'b1110, 1'b1, 1'b0);
    tick('0, '1, 1'b1, 1'b0);
    checks++;
    if ({o_Evt_valid, o_Evt_key, o_Evt_press} !== 4'b1001) begin
      errors++;
      $display("FAIL simul_first got v=%b k=%0d p=%b want v=1 k=0 p=1",
               o_Evt_valid, o_Evt_key, o_Evt_press);
    end
    tick('0, '1, 1'b1, 1'b0);
    checks++;
    if ({o_Evt_valid, o_Evt_key, o_Evt_press} !== 4'b1100) begin
      errors++;
      $display("FAIL simul_second got v=%b k=%0d p=%b want v=1 k=2 p=0",
               o_Evt_valid, o_Evt_key, o_Evt_press);
    end
    tick('0, '1, 1'b1, 1'b0);
    checks++;
    if (o_Evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_end valid=%b want 0", o_Evt_valid);
    end
    // Pointer at 3 means key 3 beats key 2.
    tick(4'b1100, 4'b0011, 1'b1, 1'b0);
    tick('0, '1, 1'b1, 1'b0);
    checks++;
    if ({o_Evt_valid, o_Evt_key} !== 3'b111) begin
      errors++;
      $display("FAIL simul_rr3 got v=%b k=%0d want v=1 k=3",
               o_Evt_valid, o_Evt_key);
    end
    tick('0, '1, 1'b1, 1'b0);
  endtask

  task automatic test_fairness();
    do_reset();
    tick(4'b0001, 4'b1110, 1'b1, 1'b0);
    tick('0, '1, 1'b1, 1'b0);
    tick('0, '1, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      tick(4'b1001, 4'b0110, 1'b1, 1'b0);
      tick('0, '1, 1'b1, 1'b0);
      checks++;
      if ({o_Evt_valid, o_Evt_key} !== 3'b111) begin
        errors++;
        $display("FAIL fair_r%0d_a got v=%b k=%0d want v=1 k=3",
                 r, o_Evt_valid, o_Evt_key);
      end
      tick('0, '1, 1'b1, 1'b0);
      checks++;
      if ({o_Evt_valid, o_Evt_key} !== 3'b100) begin
        errors++;
        $display("FAIL fair_r%0d_b got v=%b k=%0d want v=1 k=0",
                 r, o_Evt_valid, o_Evt_key);
      end
      tick('0, '1, 1'b1, 1'b0);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    tick(4'b0001, 4'b1110, 1'b0, 1'b0);
    tick('0, '1, 1'b0, 1'b0);
    tick(4'b0100, 4'b1011, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick('0, '1, 1'b0, 1'b0);
    tick(4'b0100, 4'b1111, 1'b0, 1'b0);
    checks++;
    if (o_Ovr !== 4'b0100 || {o_Evt_valid, o_Evt_key} !== 3'b100) begin
      errors++;
      $display("FAIL ovr_set got ovr=%b v=%b k=%0d want ovr=0100 v=1 k=0",
               o_Ovr, o_Evt_valid, o_Evt_key);
    end
    tick('0, '1, 1'b1, 1'b0);
    checks++;
    if ({o_Evt_valid, o_Evt_key, o_Evt_press} !== 4'b1100) begin
      errors++;
      $display("FAIL ovr_evt got v=%b k=%0d p=%b want v=1 k=2 p=0",
               o_Evt_valid, o_Evt_key, o_Evt_press);
    end
    tick('0, '1, 1'b1, 1'b0);
    checks++;
    if (o_Evt_valid !== 1'b0 || o_Ovr !== 4'b0100) begin
      errors++;
      $display("FAIL ovr_drain got v=%b ovr=%b want v=0 ovr=0100",
               o_Evt_valid, o_Ovr);
    end
    tick('0, '1, 1'b1, 1'b1);
    checks++;
    if (o_Ovr !== 4'b0000) begin
      errors++;
      $display("FAIL ovr_clr got ovr=%b want 0000", o_Ovr);
    end
  endtask

  task automatic test_same_edge();
    do_reset();
    tick(4'b0001, 4'b1110, 1'b0, 1'b0);
    tick(4'b0010, 4'b1101, 1'b0, 1'b0);
    tick(4'b0010, 4'b1111, 1'b1, 1'b0);
    checks++;
    if ({o_Evt_valid, o_Evt_key, o_Evt_press} !== 4'b1011) begin
      errors++;
      $display("FAIL same_old got v=%b k=%0d p=%b want v=1 k=1 p=1",
               o_Evt_valid, o_Evt_key, o_Evt_press);
    end
    tick('0, '1, 1'b1, 1'b0);
    checks++;
    if ({o_Evt_valid, o_Evt_key, o_Evt_press} !== 4'b1010) begin
      errors++;
      $display("FAIL same_new got v=%b k=%0d p=%b want v=1 k=1 p=0",
               o_Evt_valid, o_Evt_key, o_Evt_press);
    end
    tick('0, '1, 1'b1, 1'b0);
    checks++;
    if (o_Evt_valid !== 1'b0 || o_Ovr !== 4'b0000) begin
      errors++;
      $display("FAIL same_end got v=%b ovr=%b want v=0 ovr=0000",
               o_Evt_valid, o_Ovr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(4'b1111, 4'b0000, 1'b0, 1'b0);
    tick('0, '1, 1'b0, 1'b0);
    checks++;
    if (o_Evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre valid=%b want 1", o_Evt_valid);
    end
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (o_Evt_valid !== 1'b0 || o_Evt_key !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_async got v=%b k=%0d want v=0 k=0",
               o_Evt_valid, o_Evt_key);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick('0, '1, 1'b1, 1'b0);
      checks++;
      if (o_Evt_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet%0d valid=%b want 0", i, o_Evt_valid);
      end
    end
    tick(4'b1000, 4'b0111, 1'b1, 1'b0);
    tick('0, '1, 1'b1, 1'b0);
    checks++;
    if ({o_Evt_valid, o_Evt_key, o_Evt_press} !== 4'b1111) begin
      errors++;
      $display("FAIL rstmid_new got v=%b k=%0d p=%b want v=1 k=3 p=1",
               o_Evt_valid, o_Evt_key, o_Evt_press);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] f;
    logic [N-1:0] s;
    logic         r;
    logic         c;
    int           rdy_pct;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rdy_pct = (n < 300) ? 70 : 25;
      f = N'($urandom) & N'($urandom);
      s = N'($urandom);
      r = ($urandom_range(99) < rdy_pct);
      c = ($urandom_range(19) == 0);
      tick(f, s, r, c);
      checks++;
      if (o_Evt_valid !== m_valid) begin
        errors++;
        $display("FAIL rnd_valid@%0d got %b want %b", n, o_Evt_valid, m_valid);
      end
      checks++;
      if (o_Evt_key !== 2'(m_key) || o_Evt_press !== m_press) begin
        errors++;
        $display("FAIL rnd_evt@%0d got k=%0d p=%b want k=%0d p=%b",
                 n, o_Evt_key, o_Evt_press, m_key, m_press);
      end
      checks++;
      if (o_Ovr !== m_ovr) begin
        errors++;
        $display("FAIL rnd_ovr@%0d got %b want %b", n, o_Ovr, m_ovr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_overrun();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
